// File: rtl/frame_sync_ctrl_if.sv
// Serial receive bus for frame_sync_ctrl: incoming bit stream plus
// the frame-alignment status returned to downstream deframing logic.
interface frame_sync_ctrl_if #(
  parameter int CW = 4
);
  logic          in_valid;
  logic          in;
  logic          locked;
  logic          frame_start;
  logic          sync_err;
  logic [CW-1:0] bit_pos;
  logic [1:0]    fsm_state;

  modport master (
    output in_valid, in,
    input  locked, frame_start, sync_err, bit_pos, fsm_state
  );

  modport slave (
    input  in_valid, in,
    output locked, frame_start, sync_err, bit_pos, fsm_state
  );
endinterface

// File: rtl/frame_sync_ctrl.sv
// Frame-synchronisation controller: overlapping 1101 sync-word detector
// sequenced through HUNT / VERIFY / LOCK with a flywheel position counter
// that tolerates up to MISS_MAX-1 consecutive corrupted sync words.
module frame_sync_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int CONFIRM   = 2,
  parameter int MISS_MAX  = 3,
  parameter int CW        = 4
) (
  input  logic            clk,
  input  logic            rst,
  frame_sync_ctrl_if.slave bus
);

  localparam int CNT_MAX = (CONFIRM > MISS_MAX) ? CONFIRM : MISS_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]    POS_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] GOOD_LIM  = CNT_W'(CONFIRM);
  localparam logic [CNT_W-1:0] MISS_LIM  = CNT_W'(MISS_MAX);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  // Detector states name the longest received suffix that prefixes 1101
  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_1    = 2'd1,
    D_11   = 2'd2,
    D_110  = 2'd3
  } det_t;

  state_t           r_state, w_state_nxt;
  det_t             r_det, w_det_nxt;
  logic [CW-1:0]    r_pos, w_pos_nxt;
  logic [CNT_W-1:0] r_good, w_good_nxt, w_good_inc;
  logic [CNT_W-1:0] r_miss, w_miss_nxt, w_miss_inc;
  logic             w_hit, w_exp, w_fs_nxt, w_se_nxt;
  logic             r_locked, r_frame_start, r_sync_err;
  logic [CW-1:0]    r_bit_pos;

  // Mealy 1101 detector: next state and hit on the current valid bit
  always_comb begin
    w_det_nxt = r_det;
    w_hit     = 1'b0;
    if (bus.in_valid) begin
      case (r_det)
        D_IDLE: w_det_nxt = bus.in ? D_1  : D_IDLE;
        D_1:    w_det_nxt = bus.in ? D_11 : D_IDLE;
        D_11:   w_det_nxt = bus.in ? D_11 : D_110;
        D_110: begin
          // trailing 1 of a completed word is the first 1 of the next
          w_det_nxt = bus.in ? D_1 : D_IDLE;
          w_hit     = bus.in;
        end
      endcase
    end
  end

  assign w_exp      = bus.in_valid && (r_pos == POS_LAST);
  assign w_good_inc = (r_good == GOOD_LIM) ? r_good : r_good + 1'b1;
  assign w_miss_inc = (r_miss == MISS_LIM) ? r_miss : r_miss + 1'b1;

  // Sync FSM next state, counters and pulse outputs
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_good_nxt  = r_good;
    w_miss_nxt  = r_miss;
    w_fs_nxt    = 1'b0;
    w_se_nxt    = 1'b0;
    if (bus.in_valid) begin
      w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
      case (r_state)
        HUNT: begin
          if (w_hit) begin
            w_pos_nxt  = '0;
            w_good_nxt = CNT_W'(1);
            if (CONFIRM == 1) begin
              w_state_nxt = LOCK;
              w_miss_nxt  = '0;
              w_fs_nxt    = 1'b1;
            end else begin
              w_state_nxt = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (w_exp) begin
            if (w_hit) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc == GOOD_LIM) begin
                w_state_nxt = LOCK;
                w_miss_nxt  = '0;
                w_fs_nxt    = 1'b1;
              end
            end else begin
              w_state_nxt = HUNT;
              w_good_nxt  = '0;
            end
          end
        end
        LOCK: begin
          if (w_exp) begin
            if (w_hit) begin
              w_miss_nxt = '0;
              w_fs_nxt   = 1'b1;
            end else begin
              w_se_nxt = 1'b1;
              if (w_miss_inc == MISS_LIM) begin
                w_state_nxt = HUNT;
                w_miss_nxt  = '0;
              end else begin
                // flywheel: keep framing on the expected position
                w_miss_nxt = w_miss_inc;
                w_fs_nxt   = 1'b1;
              end
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // State, detector, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= HUNT;
      r_det         <= D_IDLE;
      r_pos         <= '0;
      r_good        <= '0;
      r_miss        <= '0;
      r_locked      <= 1'b0;
      r_frame_start <= 1'b0;
      r_sync_err    <= 1'b0;
      r_bit_pos     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_det         <= w_det_nxt;
      r_pos         <= w_pos_nxt;
      r_good        <= w_good_nxt;
      r_miss        <= w_miss_nxt;
      r_locked      <= (w_state_nxt == LOCK);
      r_frame_start <= w_fs_nxt;
      r_sync_err    <= w_se_nxt;
      if (bus.in_valid) begin
        r_bit_pos <= r_pos;
      end
    end
  end

  assign bus.locked      = r_locked;
  assign bus.frame_start = r_frame_start;
  assign bus.sync_err    = r_sync_err;
  assign bus.bit_pos     = r_bit_pos;
  assign bus.fsm_state   = r_state;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Testbench for frame_sync_ctrl (FRAME_LEN=8, CONFIRM=2, MISS_MAX=3).
module tb_frame_sync_ctrl;

  localparam int FL   = 8;
  localparam int CONF = 2;
  localparam int MMAX = 3;
  localparam int CWID = 4;

  typedef struct {
    logic            locked;
    logic            fs;
    logic            se;
    logic [CWID-1:0] bp;
    logic [1:0]      fsm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  // reference model state (shift-window detector)
  logic [3:0] m_win;
  int         m_st, m_pos, m_good, m_miss;
  exp_t       m_out;

  always #5 clk = ~clk;

  frame_sync_ctrl_if #(.CW(CWID)) bus();

  frame_sync_ctrl #(
    .FRAME_LEN(FL),
    .CONFIRM(CONF),
    .MISS_MAX(MMAX),
    .CW(CWID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic model_step(input logic r, input logic v, input logic b);
    logic [3:0] w;
    bit hit, ex;
    int np;
    m_out.fs = 1'b0;
    m_out.se = 1'b0;
    if (r) begin
      m_win = 4'b0000; m_st = 0; m_pos = 0; m_good = 0; m_miss = 0;
      m_out.locked = 1'b0; m_out.bp = '0; m_out.fsm = 2'd0;
    end else if (v) begin
      w     = {m_win[2:0], b};
      m_win = w;
      hit   = (w == 4'b1101);
      ex    = (m_pos == FL - 1);
      m_out.bp = CWID'(m_pos);
      np = (m_pos + 1) % FL;
      case (m_st)
        0: if (hit) begin
          np = 0; m_good = 1;
          if (CONF == 1) begin m_st = 2; m_miss = 0; m_out.fs = 1'b1; end
          else m_st = 1;
        end
        1: if (ex) begin
          if (hit) begin
            m_good++;
            if (m_good >= CONF) begin m_st = 2; m_miss = 0; m_out.fs = 1'b1; end
          end else begin
            m_st = 0; m_good = 0;
          end
        end
        default: if (ex) begin
          if (hit) begin
            m_miss = 0; m_out.fs = 1'b1;
          end else begin
            m_out.se = 1'b1; m_miss++;
            if (m_miss >= MMAX) begin m_st = 0; m_miss = 0; end
            else m_out.fs = 1'b1;
          end
        end
      endcase
      m_pos = np;
      m_out.locked = (m_st == 2);
      m_out.fsm    = 2'(m_st);
    end
  endtask

  // Drive one cycle, push its expected outputs, return just after the edge
  task automatic drive(input logic r, input logic v, input logic b);
    @(negedge clk);
    rst = r;
    bus.in_valid = v;
    bus.in = b;
    model_step(r, v, b);
    sb.push_back(m_out);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every driven cycle is compared against the model
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if ({bus.locked, bus.frame_start, bus.sync_err, bus.bit_pos, bus.fsm_state}
          !== {e.locked, e.fs, e.se, e.bp, e.fsm}) begin
        bad++;
        $display("FAIL scoreboard t=%0t: got lk=%b fs=%b se=%b bp=%0d st=%0d required lk=%b fs=%b se=%b bp=%0d st=%0d",
                 $time, bus.locked, bus.frame_start, bus.sync_err, bus.bit_pos, bus.fsm_state,
                 e.locked, e.fs, e.se, e.bp, e.fsm);
      end
    end
  end

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    total++;
    if ({bus.locked, bus.frame_start, bus.sync_err, bus.bit_pos, bus.fsm_state} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got lk=%b fs=%b se=%b bp=%0d st=%0d required all 0",
               bus.locked, bus.frame_start, bus.sync_err, bus.bit_pos, bus.fsm_state);
    end
  endtask

  task automatic test_acquire();
    logic [7:0] f;
    drive(1'b1, 1'b0, 1'b0);
    f = 8'hD0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, f[7-(i%8)]);
      if (i == 3) begin
        total++;
        if (bus.fsm_state !== 2'd1) begin
          bad++; $display("FAIL acq_verify: fsm_state=%0d required 1", bus.fsm_state);
        end
      end
      if (i == 11) begin
        total++;
        if ({bus.locked, bus.frame_start} !== 2'b11) begin
          bad++; $display("FAIL acq_lock: lk=%b fs=%b required 1 1", bus.locked, bus.frame_start);
        end
      end
      if (i == 19 || i == 27 || i == 35) begin
        total++;
        if (bus.frame_start !== 1'b1 || bus.bit_pos !== 4'd7) begin
          bad++; $display("FAIL acq_pulse bit %0d: fs=%b bp=%0d required 1 7", i, bus.frame_start, bus.bit_pos);
        end
      end
    end
  endtask

  task automatic test_false_sync();
    logic [7:0] fr [3];
    logic [7:0] f;
    logic seen;
    fr = '{8'hD0, 8'h00, 8'h00};
    seen = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      f = fr[i/8];
      drive(1'b0, 1'b1, f[7-(i%8)]);
      seen = seen | bus.locked | bus.frame_start;
      if (i == 3) begin
        total++;
        if (bus.fsm_state !== 2'd1) begin
          bad++; $display("FAIL false_verify: fsm_state=%0d required 1", bus.fsm_state);
        end
      end
      if (i == 11) begin
        total++;
        if (bus.fsm_state !== 2'd0) begin
          bad++; $display("FAIL false_hunt: fsm_state=%0d required 0", bus.fsm_state);
        end
      end
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL false_nolock: locked/frame_start seen=%b required 0", seen);
    end
  endtask

  task automatic test_flywheel();
    logic [7:0] fr [8];
    logic [7:0] f;
    int both;
    fr = '{8'hD0, 8'hD0, 8'hD0, 8'hC0, 8'hD0, 8'hC0, 8'hC0, 8'hC0};
    both = 0;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      f = fr[i/8];
      drive(1'b0, 1'b1, f[7-(i%8)]);
      if (i < 40 && bus.frame_start === 1'b1 && bus.sync_err === 1'b1) both++;
      if (i == 27 || i == 43) begin
        total++;
        if ({bus.sync_err, bus.frame_start, bus.locked} !== 3'b111) begin
          bad++; $display("FAIL fly_miss bit %0d: se=%b fs=%b lk=%b required 1 1 1",
                          i, bus.sync_err, bus.frame_start, bus.locked);
        end
      end
      if (i == 59) begin
        total++;
        if ({bus.sync_err, bus.frame_start, bus.locked, bus.fsm_state} !== 5'b10000) begin
          bad++; $display("FAIL fly_drop: se=%b fs=%b lk=%b st=%0d required 1 0 0 0",
                          bus.sync_err, bus.frame_start, bus.locked, bus.fsm_state);
        end
      end
    end
    total++;
    if (both !== 1) begin
      bad++; $display("FAIL fly_single: both-high cycles=%0d required 1", both);
    end
  endtask

  task automatic test_overlap();
    logic [7:0] fr [3];
    logic [7:0] f;
    fr = '{8'hDB, 8'hD0, 8'hD0};
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      f = fr[i/8];
      drive(1'b0, 1'b1, f[7-(i%8)]);
      if (i == 6) begin
        total++;
        if ({bus.fsm_state, bus.frame_start} !== 3'b010) begin
          bad++; $display("FAIL ovl_ignore: st=%0d fs=%b required 1 0", bus.fsm_state, bus.frame_start);
        end
      end
      if (i == 11 || i == 19) begin
        total++;
        if ({bus.locked, bus.frame_start} !== 2'b11) begin
          bad++; $display("FAIL ovl_lock bit %0d: lk=%b fs=%b required 1 1", i, bus.locked, bus.frame_start);
        end
      end
    end
  endtask

  task automatic test_gapped();
    logic [7:0] f;
    int vi, npulse;
    f = 8'hD0;
    vi = 0;
    npulse = 0;
    drive(1'b1, 1'b0, 1'b0);
    while (vi < 40) begin
      if ($urandom_range(0, 2) == 0) begin
        drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        total++;
        if ({bus.frame_start, bus.sync_err} !== 2'b00) begin
          bad++; $display("FAIL gap_pulse: fs=%b se=%b required 0 0", bus.frame_start, bus.sync_err);
        end
      end else begin
        drive(1'b0, 1'b1, f[7-(vi%8)]);
        if (bus.frame_start === 1'b1) begin
          npulse++;
          total++;
          if (!(vi == 11 || vi == 19 || vi == 27 || vi == 35)) begin
            bad++; $display("FAIL gap_pos: frame_start at valid bit %0d required 11/19/27/35", vi);
          end
        end
        vi++;
      end
    end
    total++;
    if (npulse !== 4) begin
      bad++; $display("FAIL gap_count: pulses=%0d required 4", npulse);
    end
  endtask

  task automatic test_reset_locked();
    logic [7:0] f;
    f = 8'hD0;
    total++;
    if (bus.locked !== 1'b1) begin
      bad++; $display("FAIL rl_pre: locked=%b required 1", bus.locked);
    end
    drive(1'b1, 1'b1, 1'b1);
    total++;
    if ({bus.locked, bus.bit_pos, bus.fsm_state} !== 7'd0) begin
      bad++; $display("FAIL rl_reset: lk=%b bp=%0d st=%0d required 0 0 0",
                      bus.locked, bus.bit_pos, bus.fsm_state);
    end
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, 1'b1, f[7-(i%8)]);
      if (i == 3) begin
        total++;
        if (bus.fsm_state !== 2'd1) begin
          bad++; $display("FAIL rl_verify: fsm_state=%0d required 1", bus.fsm_state);
        end
      end
      if (i == 11 || i == 19) begin
        total++;
        if ({bus.locked, bus.frame_start, bus.bit_pos} !== {2'b11, 4'd7}) begin
          bad++; $display("FAIL rl_lock bit %0d: lk=%b fs=%b bp=%0d required 1 1 7",
                          i, bus.locked, bus.frame_start, bus.bit_pos);
        end
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in = 1'b0;
    test_reset();
    test_acquire();
    test_false_sync();
    test_flywheel();
    test_overlap();
    test_gapped();
    test_reset_locked();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain: pending=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_sync_ctrl.md
# frame_sync_ctrl

Frame-synchronisation controller for the serial receive path. It runs an overlapping Mealy 1101 sync-word detector on every valid input bit and sequences it through hunt, verify and lock phases. While locked it maintains a flywheel bit counter and tolerates a bounded number of corrupted sync words. Downstream deframing logic uses its `frame_start`, `bit_pos` and `locked` outputs.

## Interface
- `FRAME_LEN`, 16: bits per frame, including the 4-bit sync word; legal range ≥ 8.
- `CONFIRM`, 2: consecutive correctly spaced sync hits, including the first, required to enter LOCK; legal range ≥ 1.
- `MISS_MAX`, 3: consecutive missed syncs in LOCK that force return to HUNT; legal range ≥ 1.
- `CW`, 4: width of `bit_pos`; must satisfy 2^CW ≥ FRAME_LEN.
- `clk  in  1`: single clock; all logic on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `in_valid  in  1`: `in` carries a serial bit this cycle.
- `in  in  1`: serial data bit, MSB-first stream.
- `locked  out  1`: registered; high while the FSM is in LOCK.
- `frame_start  out  1`: registered one-cycle pulse at each expected sync position in LOCK.
- `sync_err  out  1`: registered one-cycle pulse when an expected sync is missing in LOCK.
- `bit_pos  out  CW`: registered position within the frame; 0 is the first bit after the sync word.
- `fsm_state  out  2`: HUNT=0, VERIFY=1, LOCK=2; 3 is unused.

## Operation
- **Detector**
  - 4-state overlapping 1101 Mealy detector, advanced only on `in_valid`.
  - `hit` is combinational and is high when the current valid bit completes 1101.
  - The detector runs continuously in all FSM states and is never reset except by `rst`.
- **Position counter `pos`**
  - Advances only on `in_valid`.
  - Set to 0 on the valid bit that causes HUNT→VERIFY.
  - Otherwise increments each valid bit and wraps FRAME_LEN-1→0.
  - `exp` = (`pos` == FRAME_LEN-1) and `in_valid`.
- **HUNT**
  - `hit` → VERIFY, with `good`=1 and `pos`=0.
  - If CONFIRM=1, go directly to LOCK instead and pulse `frame_start`.
- **VERIFY**
  - Any `hit` when not `exp` is ignored.
  - On `exp` with `hit`: `good`+1. If `good`+1 == CONFIRM → LOCK, `miss`=0, pulse `frame_start`.
  - On `exp` without `hit` → HUNT, `good`=0.
- **LOCK**
  - Any `hit` when not `exp` is ignored.
  - On `exp` with `hit`: `miss`=0, pulse `frame_start`.
  - On `exp` without `hit`: `miss`+1 and pulse `sync_err`.
    - If `miss`+1 == MISS_MAX → HUNT, `locked`=0, no `frame_start`, `miss`=0.
    - Otherwise stay in LOCK (flywheel) and also pulse `frame_start`.
- **Counters**: `good` and `miss` saturate at their limits. Width is clog2(max(CONFIRM, MISS_MAX)+1).
- **Reset values**
  - `rst` has priority over everything, including `in_valid`.
  - FSM=HUNT, detector at its idle state, `pos`/`good`/`miss`=0.
  - All outputs 0.
  - Reset asserted mid-frame or in LOCK gives HUNT and `locked`=0 on the next edge.
- **`in_valid`=0**: no state, counter or detector change. `frame_start` and `sync_err` are 0. `locked`, `bit_pos` and `fsm_state` hold.

## Timing
- All outputs are registered and change at the edge that samples the corresponding valid bit, so they are visible the cycle after that bit is presented.
- Latency: a sync word completing on bit k gives `frame_start`/`sync_err`/`locked` updates in cycle k+1.
- `bit_pos` reflects the `pos` of the most recently sampled valid bit: 0 after the first post-sync bit, FRAME_LEN-1 after the sync-completing bit.
- `frame_start` and `sync_err` are never high for more than one cycle per valid bit.
- `frame_start` and `sync_err` may be high together (flywheel miss).
- Throughput: one bit per cycle; back-to-back `in_valid` is fully supported.

## Test plan
- **Acquire** (FRAME_LEN=8, CONFIRM=2): stream repeating 1101_0000 from reset.
  - Bit 3 → `fsm_state`=1.
  - Bit 11 → `locked`=1 with `frame_start` pulse.
  - `frame_start` then pulses after bits 19, 27, …; `bit_pos`=7 on each pulse.
- **False sync**: 1101 followed by 0000_0000.
  - VERIFY is entered, then HUNT after bit 11.
  - `locked` and `frame_start` never assert.
- **Flywheel** (MISS_MAX=3): in LOCK, corrupt one sync to 1100.
  - One cycle with both `sync_err` and `frame_start`; `locked` stays 1.
  - Corrupt 3 consecutive syncs: third miss → `sync_err` only, `locked`=0, `fsm_state`=0.
- **Overlap/ignore**: in VERIFY with FRAME_LEN=8, inject 1101101.
  - The hit at pos 2 is ignored.
  - Lock timing is unchanged when the next sync arrives at the expected position.
- **Gapped input**: the acquire stream with random `in_valid`=0 gaps.
  - Identical pulse sequence relative to valid bits.
  - All outputs hold during gaps; pulses are 0.
- **Reset**: assert `rst` for one cycle while locked with `in_valid`=1.
  - Next cycle: `locked`=0, `bit_pos`=0, `fsm_state`=0.
  - Reacquisition completes exactly as in the acquire scenario.
